dem_dwa_scheduler: RTL and testbench

// Element-selection scheduler for the DEM thermometer DAC. Takes a binary DAC code per sample
// and allocates that many unit elements in rotated order (data-weighted averaging) from a

---
 rtl/dem_dwa_scheduler.sv | 136 +++++++++++++
 tb/tb_dem_dwa_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dem_dwa_scheduler.sv
// Data-weighted-averaging element scheduler for the DEM thermometer DAC.
// Rotates a wrapping start pointer through the unit elements and paces the PN generator.
module dem_dwa_scheduler #(
  parameter int unsigned N_ELEM     = 8,
  parameter int unsigned CODE_W     = $clog2(N_ELEM + 1),
  parameter int unsigned PTR_W      = $clog2(N_ELEM),
  parameter int unsigned WARMUP_CYC = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              rand_en_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              code_valid_i,
  input  logic              pn_bit_i,
  output logic              pn_adv_o,
  output logic [N_ELEM-1:0] elem_sel_o,
  output logic              sel_valid_o,
  output logic [PTR_W-1:0]  ptr_o,
  output logic              code_err_o
);

  localparam int unsigned WarmW = $clog2(WARMUP_CYC + 1);
  localparam int unsigned SumW  = PTR_W + 2;

  localparam logic [SumW-1:0]   NElemSum  = SumW'(N_ELEM);
  localparam logic [CODE_W-1:0] NElemCode = CODE_W'(N_ELEM);
  localparam logic [WarmW-1:0]  WarmLast  = WarmW'(WARMUP_CYC - 1);

  typedef enum logic [1:0] {StIdle, StWarmup, StRun} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [WarmW-1:0]    warm_q, warm_d;
  logic [N_ELEM-1:0]   sel_q, sel_d;
  logic                sel_valid_q, sel_valid_d;
  logic                err_q, err_d;

  logic                over;
  logic [CODE_W-1:0]   code_c;
  logic                skip;
  logic [SumW-1:0]     sum_raw, sum_1, sum_2;

  // Bit k is on when its distance from the start pointer (mod N_ELEM) is below cnt.
  function automatic logic [N_ELEM-1:0] rot_mask(input logic [PTR_W-1:0]  start,
                                                  input logic [CODE_W-1:0] cnt);
    logic [N_ELEM-1:0] m;
    int unsigned       d;
    m = '0;
    for (int unsigned k = 0; k < N_ELEM; k++) begin
      d = k + N_ELEM - 32'(start);
      if (d >= N_ELEM) d = d - N_ELEM;
      m[k] = (d < 32'(cnt));
    end
    return m;
  endfunction

  always_comb begin
    over    = (code_i > NElemCode);
    code_c  = over ? NElemCode : code_i;
    skip    = rand_en_i & pn_bit_i;
    sum_raw = {2'b00, ptr_q} + SumW'(code_c) + SumW'(skip);
    // Sum never exceeds 2*N_ELEM, so two conditional subtractions fully reduce it.
    sum_1   = (sum_raw >= NElemSum) ? (sum_raw - NElemSum) : sum_raw;
    sum_2   = (sum_1 >= NElemSum) ? (sum_1 - NElemSum) : sum_1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    warm_d      = warm_q;
    sel_d       = sel_q;
    sel_valid_d = 1'b0;
    err_d       = 1'b0;
    pn_adv_o    = 1'b0;

    if (!enable_i) begin
      state_d = StIdle;
      ptr_d   = '0;
      warm_d  = '0;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWarmup;
          warm_d  = '0;
          sel_d   = '0;
        end
        StWarmup: begin
          pn_adv_o = 1'b1;
          sel_d    = '0;
          if (warm_q == WarmLast) begin
            state_d = StRun;
            warm_d  = '0;
          end else begin
            warm_d = warm_q + WarmW'(1);
          end
        end
        StRun: begin
          if (code_valid_i) begin
            sel_d       = rot_mask(ptr_q, code_c);
            ptr_d       = sum_2[PTR_W-1:0];
            sel_valid_d = 1'b1;
            err_d       = over;
            pn_adv_o    = rand_en_i;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      warm_q      <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      warm_q      <= warm_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      err_q       <= err_d;
    end
  end

  assign elem_sel_o  = sel_q;
  assign sel_valid_o = sel_valid_q;
  assign ptr_o       = ptr_q;
  assign code_err_o  = err_q;

endmodule

// File: tb/tb_dem_dwa_scheduler.sv
// Directed bench for dem_dwa_scheduler: scoreboard of expected selections, immediate-assert checks.
module tb_dem_dwa_scheduler;

  localparam int unsigned N = 8;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       enable_i;
  logic       rand_en_i;
  logic [3:0] code_i;
  logic       code_valid_i;
  logic       pn_bit_i;
  logic       pn_adv_o;
  logic [7:0] elem_sel_o;
  logic       sel_valid_o;
  logic [2:0] ptr_o;
  logic       code_err_o;

  typedef struct packed {
    logic [7:0] sel;
    logic [2:0] ptr;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_ptr    = 0;

  dem_dwa_scheduler dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .rand_en_i   (rand_en_i),
    .code_i      (code_i),
    .code_valid_i(code_valid_i),
    .pn_bit_i    (pn_bit_i),
    .pn_adv_o    (pn_adv_o),
    .elem_sel_o  (elem_sel_o),
    .sel_valid_o (sel_valid_o),
    .ptr_o       (ptr_o),
    .code_err_o  (code_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pop one expectation if the DUT should have produced a selection this cycle.
  task automatic collect();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sel_valid", 32'(sel_valid_o), 32'd1);
      chk("elem_sel", 32'(elem_sel_o), 32'(e.sel));
      chk("ptr", 32'(ptr_o), 32'(e.ptr));
      chk("code_err", 32'(code_err_o), 32'(e.err));
    end
  endtask

  task automatic send_code(input int code, input bit rnd, input bit pn);
    exp_t e;
    int   c;
    c = (code > N) ? N : code;
    e.sel = '0;
    for (int i = 0; i < c; i++) e.sel[(m_ptr + i) % N] = 1'b1;
    m_ptr = (m_ptr + c + int'(rnd & pn)) % N;
    e.ptr = 3'(m_ptr);
    e.err = (code > N);
    exp_q.push_back(e);
    code_i       = 4'(code);
    rand_en_i    = rnd;
    pn_bit_i     = pn;
    code_valid_i = 1'b1;
    #1;
    chk("pn_adv_accept", 32'(pn_adv_o), 32'(rnd));
    tick();
    code_valid_i = 1'b0;
    collect();
  endtask

  task automatic warmup(input string tag);
    int adv = 0;
    code_valid_i = 1'b1;
    code_i       = 4'd3;
    enable_i     = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (pn_adv_o) adv++;
      if (sel_valid_o) chk({tag, "_sel_valid_warm"}, 32'(sel_valid_o), 32'd0);
      if (i == 15) code_valid_i = 1'b0;
      tick();
    end
    chk({tag, "_adv_count"}, 32'(adv), 32'd16);
    chk({tag, "_run_idle_adv"}, 32'(pn_adv_o), 32'd0);
    chk({tag, "_run_elem_sel"}, 32'(elem_sel_o), 32'd0);
    m_ptr = 0;
  endtask

  initial begin
    reset_i      = 1'b0;
    enable_i     = 1'b0;
    rand_en_i    = 1'b0;
    code_i       = '0;
    code_valid_i = 1'b0;
    pn_bit_i     = 1'b0;
    repeat (3) tick();
    chk("rst_elem_sel", 32'(elem_sel_o), 32'd0);
    chk("rst_ptr", 32'(ptr_o), 32'd0);
    chk("rst_pn_adv", 32'(pn_adv_o), 32'd0);
    reset_i = 1'b1;
    tick();

    // Code presented while IDLE and during WARMUP must be ignored.
    warmup("t2");

    send_code(3, 1'b0, 1'b0);
    send_code(3, 1'b0, 1'b1);
    send_code(3, 1'b0, 1'b0);
    chk("t3_ptr_const", 32'(ptr_o), 32'd1);

    tick();
    chk("hold_sel_valid", 32'(sel_valid_o), 32'd0);
    chk("hold_elem_sel", 32'(elem_sel_o), 32'hC1);

    send_code(7, 1'b0, 1'b0);
    send_code(2, 1'b1, 1'b1);
    chk("t4_ptr_skip", 32'(ptr_o), 32'd3);
    send_code(5, 1'b0, 1'b0);
    send_code(2, 1'b1, 1'b0);
    chk("t4_ptr_noskip", 32'(ptr_o), 32'd2);
    send_code(3, 1'b0, 1'b0);

    send_code(9, 1'b0, 1'b0);
    chk("t5_ptr_full", 32'(ptr_o), 32'd5);
    tick();
    chk("t5_err_pulse_end", 32'(code_err_o), 32'd0);
    send_code(0, 1'b0, 1'b0);
    send_code(8, 1'b1, 1'b1);
    chk("t5_full_skip_ptr", 32'(ptr_o), 32'd6);

    // Disable collides with a valid code: IDLE wins, code dropped.
    code_i       = 4'd2;
    rand_en_i    = 1'b1;
    pn_bit_i     = 1'b1;
    code_valid_i = 1'b1;
    enable_i     = 1'b0;
    #1;
    chk("t6_pn_adv", 32'(pn_adv_o), 32'd0);
    tick();
    code_valid_i = 1'b0;
    rand_en_i    = 1'b0;
    chk("t6_sel_valid", 32'(sel_valid_o), 32'd0);
    chk("t6_ptr", 32'(ptr_o), 32'd0);
    chk("t6_elem_sel", 32'(elem_sel_o), 32'd0);
    tick();
    warmup("t6");
    send_code(4, 1'b0, 1'b0);
    send_code(6, 1'b1, 1'b1);

    // Asynchronous reset mid-RUN clears outputs without waiting for a clock.
    #2;
    reset_i = 1'b0;
    #1;
    chk("t1_elem_sel", 32'(elem_sel_o), 32'd0);
    chk("t1_ptr", 32'(ptr_o), 32'd0);
    chk("t1_sel_valid", 32'(sel_valid_o), 32'd0);
    chk("t1_pn_adv", 32'(pn_adv_o), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
